mult_arbiter: RTL and testbench
===============================

MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand width in bits; product is 2*WIDTH.
REQ-002 SHALL have port: clk  in  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: reset  in  1  synchronous active-low reset; reset==0 at a rising clk edge resets the block.
REQ-004 SHALL have port: req_valid  in  2  per-requester request valid.
REQ-005 SHALL have port: req_ready  out  2  per-requester request accept.
REQ-006 SHALL have ports: req_m0, req_q0, req_m1, req_q1  in  WIDTH each  signed two's-complement operands M and Q for requester 0 and 1.
REQ-007 SHALL have port: resp_valid  out  1  product available.
REQ-008 SHALL have port: resp_ready  in  1  consumer accepts product.
REQ-009 SHALL have port: resp_id  out  1  requester that owns resp_product.
REQ-010 SHALL have port: resp_product  out  2*WIDTH  signed product M*Q.
REQ-011 SHALL have port: busy  out  1  high in every state except IDLE.

Function
REQ-012 SHALL implement FSM IDLE -> LOAD -> RUN -> DONE -> IDLE.
REQ-013 IDLE: a request transfers when req_valid[i] && req_ready[i]; req_ready is one-hot or zero and is asserted only in IDLE.
REQ-014 Arbitration SHALL be round-robin: with both valid, grant the requester not granted last. After reset, requester 0 has priority.
REQ-015 On a transfer, the block SHALL latch the operands and id, then go to LOAD. Operand changes after the transfer SHALL have no effect.
REQ-016 LOAD (1 cycle): the block SHALL initialise the Booth core with accumulator=0, Q register=Q, q(-1)=0 and iteration counter=0.
REQ-017 RUN: each cycle SHALL perform one radix-2 Booth step: add M, subtract M or do nothing per {Q[0],q(-1)}, then an arithmetic right shift of {A,Q,q(-1)}.
REQ-018 RUN SHALL last exactly WIDTH cycles, then go to DONE.
REQ-019 Request-transfer edge to the resp_valid rising edge SHALL be WIDTH+2 cycles.
REQ-020 DONE: resp_valid=1, and resp_product and resp_id SHALL be held stable until resp_ready=1. Then go to IDLE on the next edge.
REQ-021 The product SHALL be the exact signed result for all operands, including M = most-negative value (-2^(WIDTH-1)) and either operand = 0.
REQ-022 A request arriving during LOAD/RUN/DONE SHALL stall (req_ready=0) and SHALL NOT be lost; the requester holds req_valid.
REQ-023 resp_ready asserted outside DONE SHALL be ignored.
REQ-024 Back-to-back: if resp_ready=1 on the DONE entry cycle, the next grant is possible the cycle after the return to IDLE.

Reset
REQ-025 Reset SHALL force: state=IDLE, req_ready=0, resp_valid=0, resp_id=0, resp_product=0, busy=0, counter=0, round-robin pointer=requester 0.
REQ-026 Reset mid-operation (LOAD/RUN/DONE) SHALL abort the operation with no response emitted. The first request after reset release is re-arbitrated from the reset state.

Configuration
REQ-027 Macro MULT_ARBITER_ZERO_BYPASS_EN, when defined: if a latched M==0 or Q==0, LOAD SHALL go directly to DONE with product 0, giving latency 2 cycles.
REQ-028 When MULT_ARBITER_ZERO_BYPASS_EN is undefined: all operands take the full WIDTH-cycle RUN, and latency is WIDTH+2.

Structure
REQ-029 Shared package mult_pkg SHALL hold the FSM state enum (IDLE, LOAD, RUN, DONE), the default WIDTH constant, and the Booth opcode encoding (NOP/ADD/SUB).
REQ-030 Sub-module booth_step SHALL be a combinational single Booth iteration: inputs A, Q, q(-1), M; outputs the next A, Q, q(-1). The arbiter SHALL instantiate it once, with registers in mult_arbiter.

Verification
REQ-031 Single request: req0 M=7, Q=2 -> resp_product=14, resp_id=0, resp_valid exactly WIDTH+2 cycles after the transfer.
REQ-032 Signs: (-2)*(-5)->10; (-5)*2->-10; 2*(-5)->-10; (-255)*313->-79815, all sign-extended to 64 bits.
REQ-033 Contention: req0 and req1 both valid in the same cycle with M=3,Q=3 and M=-2,Q=-3 -> grant 0 first (9), then 1 (6); repeat both -> grant order 1 then 0.
REQ-034 Backpressure: hold resp_ready=0 for 10 cycles in DONE -> product and id stable, req_ready=0 throughout; release -> IDLE on the next edge.
REQ-035 Zero/limits: M=0xF00000F5, Q=0 -> 0 (latency 2 with the macro, WIDTH+2 without); M=0x80000000, Q=0x80000000 -> 0x4000000000000000.
REQ-036 Reset at RUN cycle 10 -> resp_valid never asserts, busy=0 next cycle; a subsequent M=1, Q=0xCF request -> 0xCF.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared types for the two-requester Booth multiplier: FSM states, default width, Booth opcodes.
// Included by booth_step and mult_arbiter; holds no logic beyond the Booth pair decoder.
package mult_pkg;

  localparam int WIDTH_DEFAULT = 32;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  typedef enum logic [1:0] {BOOTH_NOP, BOOTH_ADD, BOOTH_SUB} booth_op_t;

  function automatic booth_op_t booth_decode(input logic q0, input logic qm1);
    case ({q0, qm1})
      2'b01:   return BOOTH_ADD;
      2'b10:   return BOOTH_SUB;
      default: return BOOTH_NOP;
    endcase
  endfunction

endpackage

// File: rtl/booth_step.sv
// One combinational radix-2 Booth iteration: conditional add/sub of M, then arithmetic shift of {A,Q,q-1}.
// Zero latency; no flow control.
module booth_step
  import mult_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic [WIDTH:0]   a_in,
  input  logic [WIDTH-1:0] q_in,
  input  logic             qm1_in,
  input  logic [WIDTH-1:0] m_in,
  output logic [WIDTH:0]   a_out,
  output logic [WIDTH-1:0] q_out,
  output logic             qm1_out
);

  // A carries one guard bit so that subtracting the most-negative M cannot overflow.
  logic [WIDTH:0] m_ext;
  logic [WIDTH:0] sum;

  assign m_ext = {m_in[WIDTH-1], m_in};

  always_comb begin
    sum = a_in;
    case (booth_decode(q_in[0], qm1_in))
      BOOTH_ADD: sum = a_in + m_ext;
      BOOTH_SUB: sum = a_in - m_ext;
      default:   sum = a_in;
    endcase
  end

  assign a_out   = {sum[WIDTH], sum[WIDTH:1]};
  assign q_out   = {sum[0], q_in[WIDTH-1:1]};
  assign qm1_out = q_in[0];

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin arbitrated signed Booth multiplier; WIDTH+2 cycles handshake-to-result, result held until resp_ready.
// Optional MULT_ARBITER_ZERO_BYPASS_EN skips RUN when an operand is zero (latency 2); requests stall while busy.
module mult_arbiter
  import mult_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [WIDTH-1:0]   req_m0,
  input  logic [WIDTH-1:0]   req_q0,
  input  logic [WIDTH-1:0]   req_m1,
  input  logic [WIDTH-1:0]   req_q1,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic               resp_id,
  output logic [2*WIDTH-1:0] resp_product,
  output logic               busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   m_reg, q_reg, q_nxt;
  logic [WIDTH:0]     a_reg, a_nxt;
  logic               qm1_reg, qm1_nxt;
  logic [CW-1:0]      cnt;
  logic               id_reg;
  logic               prio;
  logic [2*WIDTH-1:0] prod_reg;
  logic               take;
  logic               last_step;
  logic               zero_op;

  booth_step #(.WIDTH(WIDTH)) u_step (
    .a_in    (a_reg),
    .q_in    (q_reg),
    .qm1_in  (qm1_reg),
    .m_in    (m_reg),
    .a_out   (a_nxt),
    .q_out   (q_nxt),
    .qm1_out (qm1_nxt)
  );

  assign take      = |(req_valid & req_ready);
  assign last_step = (cnt == CW'(WIDTH - 1));

`ifdef MULT_ARBITER_ZERO_BYPASS_EN
  assign zero_op = (m_reg == '0) || (q_reg == '0);
`else
  assign zero_op = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (take) state_nxt = LOAD;
      LOAD:    state_nxt = zero_op ? DONE : RUN;
      RUN:     if (last_step) state_nxt = DONE;
      DONE:    if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // prio only moves on a contested grant: the winner of the last tie yields the next tie.
  always_comb begin
    req_ready  = 2'b00;
    busy       = (state != IDLE);
    resp_valid = (state == DONE);
    if (state == IDLE && reset) begin
      case (req_valid)
        2'b01:   req_ready = 2'b01;
        2'b10:   req_ready = 2'b10;
        2'b11:   req_ready = prio ? 2'b10 : 2'b01;
        default: req_ready = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      m_reg    <= '0;
      q_reg    <= '0;
      a_reg    <= '0;
      qm1_reg  <= 1'b0;
      cnt      <= '0;
      id_reg   <= 1'b0;
      prio     <= 1'b0;
      prod_reg <= '0;
    end else begin
      case (state)
        IDLE: if (take) begin
          id_reg <= req_ready[1];
          m_reg  <= req_ready[1] ? req_m1 : req_m0;
          q_reg  <= req_ready[1] ? req_q1 : req_q0;
          if (req_valid == 2'b11) prio <= ~req_ready[1];
        end
        LOAD: begin
          a_reg   <= '0;
          qm1_reg <= 1'b0;
          cnt     <= '0;
          if (zero_op) prod_reg <= '0;
        end
        RUN: begin
          a_reg   <= a_nxt;
          q_reg   <= q_nxt;
          qm1_reg <= qm1_nxt;
          cnt     <= cnt + CW'(1);
          if (last_step) prod_reg <= {a_nxt[WIDTH-1:0], q_nxt};
        end
        default: ;
      endcase
    end
  end

  assign resp_id      = id_reg;
  assign resp_product = prod_reg;

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter: products, latency, round-robin order, backpressure and mid-run reset.
module tb_mult_arbiter;

  localparam int W = 32;
`ifdef MULT_ARBITER_ZERO_BYPASS_EN
  localparam int ZLAT = 2;
`else
  localparam int ZLAT = W + 2;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    req_valid;
  logic [1:0]    req_ready;
  logic [W-1:0]  req_m0, req_q0, req_m1, req_q1;
  logic          resp_valid;
  logic          resp_ready;
  logic          resp_id;
  logic [2*W-1:0] resp_product;
  logic          busy;

  int total = 0;
  int bad   = 0;

  mult_arbiter #(.WIDTH(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_m0       (req_m0),
    .req_q0       (req_q0),
    .req_m1       (req_m1),
    .req_q1       (req_q1),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_id      (resp_id),
    .resp_product (resp_product),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h required %h", tag, got, exp);
    end
  endtask

  task automatic drive(input int id, input logic [W-1:0] m, input logic [W-1:0] q);
    if (id == 0) begin req_m0 = m; req_q0 = q; end
    else         begin req_m1 = m; req_q1 = q; end
    req_valid[id] = 1'b1;
  endtask

  task automatic wait_ready(input int id, input string tag);
    int n = 0;
    while (!req_ready[id] && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_grant"}, 64'(req_ready[id]), 64'd1);
  endtask

  // Handshake completes at the next edge; operands are then scrambled to prove they were latched.
  task automatic accept(input int id);
    @(posedge clk); #1;
    req_valid[id] = 1'b0;
    if (id == 0) begin req_m0 = 32'hA5A5_5A5A; req_q0 = 32'h1234_5678; end
    else         begin req_m1 = 32'h5A5A_A5A5; req_q1 = 32'h8765_4321; end
  endtask

  task automatic wait_resp(output int lat);
    lat = 1;
    while (!resp_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic single(input int id, input logic [W-1:0] m, input logic [W-1:0] q,
                        input longint exp, input int exp_lat, input string tag);
    int lat;
    drive(id, m, q);
    #1;
    wait_ready(id, tag);
    accept(id);
    wait_resp(lat);
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check({tag, "_prod"}, resp_product, exp);
    check({tag, "_id"}, 64'(resp_id), 64'(id));
    @(posedge clk); #1;
    check({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  task automatic round(input int first, input logic [W-1:0] m0, input logic [W-1:0] q0,
                       input logic [W-1:0] m1, input logic [W-1:0] q1,
                       input longint p0, input longint p1, input string tag);
    int lat;
    int other;
    other = 1 - first;
    drive(0, m0, q0);
    drive(1, m1, q1);
    #1;
    check({tag, "_first_rdy"}, 64'(req_ready), (first == 1) ? 64'd2 : 64'd1);
    accept(first);
    wait_resp(lat);
    check({tag, "_first_id"}, 64'(resp_id), 64'(first));
    check({tag, "_first_prod"}, resp_product, (first == 1) ? p1 : p0);
    @(posedge clk); #1;
    check({tag, "_second_rdy"}, 64'(req_ready), (other == 1) ? 64'd2 : 64'd1);
    accept(other);
    wait_resp(lat);
    check({tag, "_second_id"}, 64'(resp_id), 64'(other));
    check({tag, "_second_prod"}, resp_product, (other == 1) ? p1 : p0);
    @(posedge clk); #1;
  endtask

  initial begin
    int lat;
    int seen;
    reset      = 1'b0;
    req_valid  = 2'b00;
    resp_ready = 1'b1;
    req_m0 = '0; req_q0 = '0; req_m1 = '0; req_q1 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_resp_id", 64'(resp_id), 64'd0);
    check("rst_resp_product", resp_product, 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    single(0, 7, 2, 14, W + 2, "basic");
    single(0, -2, -5, 10, W + 2, "negneg");
    single(1, -5, 2, -10, W + 2, "negpos");
    single(0, 2, -5, -10, W + 2, "posneg");
    single(1, -255, 313, -79815, W + 2, "wide");
    single(0, 32'hF00000F5, 0, 0, ZLAT, "zero_q");
    single(1, 0, 32'h0000_0005, 0, ZLAT, "zero_m");
    single(1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, W + 2, "minmin");

    round(0, 3, 3, -2, -3, 9, 6, "rr1");
    round(1, 3, 3, -2, -3, 9, 6, "rr2");

    // Hold the result in DONE while requester 1 waits behind it.
    resp_ready = 1'b0;
    drive(0, 32'h0000_1234, 32'h0000_0010);
    #1;
    wait_ready(0, "bp");
    accept(0);
    wait_resp(lat);
    check("bp_lat", 64'(lat), 64'(W + 2));
    drive(1, 6, 7);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_hold_prod", resp_product, 64'h0000_0000_0001_2340);
      check("bp_hold_id", 64'(resp_id), 64'd0);
      check("bp_hold_vld", 64'(resp_valid), 64'd1);
      check("bp_hold_rdy", 64'(req_ready), 64'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_busy", 64'(busy), 64'd0);
    check("bp_release_rdy", 64'(req_ready), 64'd2);
    accept(1);
    wait_resp(lat);
    check("bp_stalled_prod", resp_product, 42);
    check("bp_stalled_id", 64'(resp_id), 64'd1);
    @(posedge clk); #1;

    // Contested grant to 0 moves the pointer to 1; reset must restore priority to 0.
    drive(0, 100, 3);
    drive(1, 9, 9);
    #1;
    check("abort_rdy", 64'(req_ready), 64'd1);
    accept(0);
    req_valid[1] = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    check("abort_busy_pre", 64'(busy), 64'd1);
    reset = 1'b0;
    @(posedge clk); #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_vld", 64'(resp_valid), 64'd0);
    check("abort_rdy_rst", 64'(req_ready), 64'd0);
    check("abort_prod", resp_product, 64'd0);
    reset = 1'b1;
    seen = 0;
    repeat (50) begin
      @(posedge clk); #1;
      if (resp_valid) seen++;
    end
    check("abort_no_resp", 64'(seen), 64'd0);
    round(0, 1, 32'h0000_00CF, 4, 5, 64'h0000_00CF, 20, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
